divisor_secuencial: RTL and testbench

//   Signed restoring divider for the calculator arithmetic cores; the inverse of the shift-add multiplier.

---
 rtl/div_pkg.sv | 18 +
 rtl/divisor_secuencial_if.sv | 26 ++
 rtl/div_control.sv | 53 +++++
 rtl/divisor_secuencial.sv | 116 +++++++++++
 tb/tb_divisor_secuencial.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed restoring divider:
// default width, 3-bit FSM state encoding and iteration count sizing.
package div_pkg;

   localparam int DIV_WIDTH = 16;
   localparam int ITER      = DIV_WIDTH;
   localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_LOAD  = 3'd1;
   localparam state_t S_SHIFT = 3'd2;
   localparam state_t S_SUB   = 3'd3;
   localparam state_t S_FIX   = 3'd4;
   localparam state_t S_END   = 3'd5;

endpackage

// File: rtl/divisor_secuencial_if.sv
// init/DONE handshake bundle shared with the multiplier core; the calculator
// side is the master, the arithmetic core is the slave.
interface divisor_secuencial_if
   import div_pkg::*;
   #(parameter int WIDTH = DIV_WIDTH);

   logic             init;
   logic [WIDTH-1:0] Dividendo;
   logic [WIDTH-1:0] Divisor;
   logic [WIDTH-1:0] Cociente;
   logic [WIDTH-1:0] Residuo;
   logic             DONE;
   logic             DIV0;
   logic             OVF;

   modport master (
      output init, Dividendo, Divisor,
      input  Cociente, Residuo, DONE, DIV0, OVF
   );

   modport slave (
      input  init, Dividendo, Divisor,
      output Cociente, Residuo, DONE, DIV0, OVF
   );

endinterface

// File: rtl/div_control.sv
// Divider sequencer: walks LOAD, then SHIFT/SUB once per quotient bit, then FIX,
// and emits one-hot datapath strobes decoded from the current state.
module div_control
   import div_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic init,
   input  logic b_zero,
   input  logic cnt_zero,
   output logic start,
   output logic ld,
   output logic sh,
   output logic sub,
   output logic dec,
   output logic fix,
   output logic done
);

   state_t state;
   state_t state_nxt;

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (init) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = b_zero ? S_FIX : S_SHIFT;
         S_SHIFT: state_nxt = S_SUB;
         S_SUB:   state_nxt = cnt_zero ? S_FIX : S_SHIFT;
         S_FIX:   state_nxt = S_END;
         S_END:   if (init) state_nxt = S_LOAD;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      start = init && ((state == S_IDLE) || (state == S_END));
      ld    = (state == S_LOAD);
      sh    = (state == S_SHIFT);
      sub   = (state == S_SUB);
      dec   = (state == S_SUB);
      fix   = (state == S_FIX);
      done  = (state == S_END);
   end

endmodule

// File: rtl/divisor_secuencial.sv
// Signed restoring divider: divides operand magnitudes one bit per SHIFT/SUB pair,
// then applies signs and the divide-by-zero / overflow special cases in FIX.
module divisor_secuencial
   import div_pkg::*;
   #(parameter int WIDTH = DIV_WIDTH)
(
   input  logic                 clk,
   input  logic                 reset,
   divisor_secuencial_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

   logic start, ld, sh, sub, dec, fix, done;

   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] a_lat;
   logic [CW-1:0]    count;
   logic             sign_q, sign_r, bz_lat, ovf_lat;
   logic [WIDTH-1:0] coc_r, res_r;
   logic             div0_r, ovf_r;

   logic [WIDTH+1:0] diff;
   logic [CW-1:0]    cnt_dec;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   assign diff    = {1'b0, r_acc} - {2'b00, b_mag};
   assign cnt_dec = count - CW'(1);

   div_control u_ctrl (
      .clk      (clk),
      .rst_n    (reset),
      .init     (bus.init),
      .b_zero   (bus.Divisor == '0),
      .cnt_zero (cnt_dec == '0),
      .start    (start),
      .ld       (ld),
      .sh       (sh),
      .sub      (sub),
      .dec      (dec),
      .fix      (fix),
      .done     (done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc   <= '0;
         q_reg   <= '0;
         b_mag   <= '0;
         a_lat   <= '0;
         count   <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         bz_lat  <= 1'b0;
         ovf_lat <= 1'b0;
         coc_r   <= '0;
         res_r   <= '0;
         div0_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         if (start) begin
            div0_r <= 1'b0;
            ovf_r  <= 1'b0;
         end
         if (ld) begin
            a_lat   <= bus.Dividendo;
            sign_q  <= bus.Dividendo[WIDTH-1] ^ bus.Divisor[WIDTH-1];
            sign_r  <= bus.Dividendo[WIDTH-1];
            q_reg   <= mag(bus.Dividendo);
            b_mag   <= mag(bus.Divisor);
            r_acc   <= '0;
            count   <= CW'(WIDTH);
            bz_lat  <= (bus.Divisor == '0);
            ovf_lat <= (bus.Dividendo == MIN_NEG) && (bus.Divisor == '1);
         end
         if (sh) begin
            r_acc <= {r_acc[WIDTH-1:0], q_reg[WIDTH-1]};
            q_reg <= {q_reg[WIDTH-2:0], 1'b0};
         end
         // A non-negative trial difference commits; otherwise R is simply kept.
         if (sub && !diff[WIDTH+1]) begin
            r_acc    <= diff[WIDTH:0];
            q_reg[0] <= 1'b1;
         end
         if (dec) count <= cnt_dec;
         if (fix) begin
            if (bz_lat) begin
               coc_r  <= '0;
               res_r  <= a_lat;
               div0_r <= 1'b1;
            end else if (ovf_lat) begin
               coc_r <= MAX_POS;
               res_r <= '0;
               ovf_r <= 1'b1;
            end else begin
               coc_r <= sign_q ? -q_reg : q_reg;
               res_r <= sign_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            end
         end
      end
   end

   assign bus.Cociente = coc_r;
   assign bus.Residuo  = res_r;
   assign bus.DONE     = done;
   assign bus.DIV0     = div0_r;
   assign bus.OVF      = ovf_r;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: directed corner cases, handshake timing,
// ignored init, mid-operation reset and randomized operands against an arithmetic model.
module tb_divisor_secuencial;
   import div_pkg::*;

   localparam int W       = 16;
   localparam int LAT_NRM = 2 * ITER + 2;
   localparam int LAT_DZ  = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   divisor_secuencial_if #(.WIDTH(W)) bus ();

   divisor_secuencial #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: plain integer division, which truncates toward zero.
   function automatic void model(input int a, input int b, output logic [W-1:0] q,
                                 output logic [W-1:0] r, output logic d0, output logic ov);
      d0 = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         q  = '0;
         r  = W'(a);
         d0 = 1'b1;
      end else if (a == -32768 && b == -1) begin
         q  = 16'h7FFF;
         r  = '0;
         ov = 1'b1;
      end else begin
         q = W'(a / b);
         r = W'(a % b);
      end
   endfunction

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic done_e0, output logic div0_e0);
      @(negedge clk);
      bus.Dividendo = a;
      bus.Divisor   = b;
      bus.init      = 1'b1;
      @(posedge clk);
      #1;
      bus.init = 1'b0;
      done_e0  = bus.DONE;
      div0_e0  = bus.DIV0;
   endtask

   // Counts edges after the accepting edge until DONE is seen; scrambles operands after LOAD
   // and optionally pulses init mid-operation. lat = -1 on timeout.
   task automatic wait_done(input int poke_at, output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (i == 1) begin
            bus.Dividendo = W'($urandom);
            bus.Divisor   = W'($urandom);
         end
         if (i == poke_at)     bus.init = 1'b1;
         if (i == poke_at + 1) bus.init = 1'b0;
         if (bus.DONE) begin
            lat = i;
            break;
         end
      end
      bus.init = 1'b0;
   endtask

   task automatic run_check(input string name, input int a, input int b, input int poke_at);
      logic [W-1:0] eq, er;
      logic         ed0, eov, de0, dz0;
      int           lat, elat;
      model(a, b, eq, er, ed0, eov);
      elat = ed0 ? LAT_DZ : LAT_NRM;
      start_op(W'(a), W'(b), de0, dz0);
      wait_done(poke_at, lat);
      n_checks++;
      if (lat !== elat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d (%0d/%0d)", name, lat, elat, a, b);
      end
      n_checks++;
      if (bus.Cociente !== eq) begin
         n_fail++;
         $display("FAIL %s quotient: got %h expected %h (%0d/%0d)", name, bus.Cociente, eq, a, b);
      end
      n_checks++;
      if (bus.Residuo !== er) begin
         n_fail++;
         $display("FAIL %s remainder: got %h expected %h (%0d/%0d)", name, bus.Residuo, er, a, b);
      end
      n_checks++;
      if ({bus.DIV0, bus.OVF} !== {ed0, eov}) begin
         n_fail++;
         $display("FAIL %s flags: got div0=%b ovf=%b expected div0=%b ovf=%b (%0d/%0d)",
                  name, bus.DIV0, bus.OVF, ed0, eov, a, b);
      end
   endtask

   task automatic test_reset();
      bus.init = 1'b0;
      bus.Dividendo = '0;
      bus.Divisor = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.Cociente, bus.Residuo, bus.DONE, bus.DIV0, bus.OVF} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got q=%h r=%h done=%b div0=%b ovf=%b expected all 0",
                  bus.Cociente, bus.Residuo, bus.DONE, bus.DIV0, bus.OVF);
      end
      @(negedge clk);
      reset = 1'b1;
      run_check("pre_reset_op", 1000, -7, 0);
      // Reset between edges must clear the outputs without waiting for a clock.
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.Cociente, bus.Residuo, bus.DONE, bus.DIV0, bus.OVF} !== '0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got q=%h r=%h done=%b expected all 0",
                  bus.Cociente, bus.Residuo, bus.DONE);
      end
      n_checks++;
      if (dut.u_ctrl.state !== S_IDLE) begin
         n_fail++;
         $display("FAIL async_reset_state: got %0d expected %0d", dut.u_ctrl.state, S_IDLE);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_directed();
      int tab [6][4] = '{
         '{  1000, -7,   -142,  6},
         '{ -1000,  7,   -142, -6},
         '{ 32767,  1,  32767,  0},
         '{-32768,  2, -16384,  0},
         '{     0,  5,      0,  0},
         '{     7,  9,      0,  7}
      };
      for (int i = 0; i < 6; i++) begin
         run_check("directed", tab[i][0], tab[i][1], 0);
         n_checks++;
         if ({bus.Cociente, bus.Residuo} !== {W'(tab[i][2]), W'(tab[i][3])}) begin
            n_fail++;
            $display("FAIL directed_const: got q=%h r=%h expected q=%h r=%h",
                     bus.Cociente, bus.Residuo, W'(tab[i][2]), W'(tab[i][3]));
         end
      end
   endtask

   task automatic test_corner();
      run_check("div0", 5, 0, 0);
      n_checks++;
      if ({bus.DIV0, bus.Cociente, bus.Residuo} !== {1'b1, 16'h0000, 16'h0005}) begin
         n_fail++;
         $display("FAIL div0_const: got div0=%b q=%h r=%h expected 1 0000 0005",
                  bus.DIV0, bus.Cociente, bus.Residuo);
      end
      run_check("ovf", -32768, -1, 0);
      n_checks++;
      if ({bus.OVF, bus.Cociente, bus.Residuo} !== {1'b1, 16'h7FFF, 16'h0000}) begin
         n_fail++;
         $display("FAIL ovf_const: got ovf=%b q=%h r=%h expected 1 7fff 0000",
                  bus.OVF, bus.Cociente, bus.Residuo);
      end
   endtask

   task automatic test_ignore_init();
      run_check("init_ignored", 1000, -7, 17);
   endtask

   task automatic test_reset_mid();
      logic de0, dz0;
      start_op(W'(1000), W'(-7), de0, dz0);
      repeat (17) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.Cociente, bus.Residuo, bus.DONE, bus.DIV0, bus.OVF} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got q=%h r=%h done=%b expected all 0",
                  bus.Cociente, bus.Residuo, bus.DONE);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (dut.u_ctrl.state !== S_IDLE || bus.DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_state: got state=%0d done=%b expected %0d 0",
                  dut.u_ctrl.state, bus.DONE, S_IDLE);
      end
      @(negedge clk);
      reset = 1'b1;
      run_check("after_mid_reset", -12345, 67, 0);
   endtask

   task automatic test_back_to_back();
      logic de0, dz0;
      int   lat;
      logic [W-1:0] eq, er;
      logic ed0, eov;
      run_check("b2b_first", 5, 0, 0);
      model(-30000, 123, eq, er, ed0, eov);
      start_op(W'(-30000), W'(123), de0, dz0);
      n_checks++;
      if ({de0, dz0} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_clear: got done=%b div0=%b expected 0 0 after accept", de0, dz0);
      end
      wait_done(0, lat);
      n_checks++;
      if (lat !== LAT_NRM || {bus.Cociente, bus.Residuo} !== {eq, er}) begin
         n_fail++;
         $display("FAIL b2b_result: got lat=%0d q=%h r=%h expected lat=%0d q=%h r=%h",
                  lat, bus.Cociente, bus.Residuo, LAT_NRM, eq, er);
      end
   endtask

   task automatic test_random();
      int a, b;
      for (int i = 0; i < 1000; i++) begin
         a = int'($signed(W'($urandom)));
         if (i % 4 == 0) b = int'($urandom_range(1, 20)) * (($urandom % 2) ? -1 : 1);
         else            b = int'($signed(W'($urandom)));
         if (i % 50 == 0) a = -32768;
         if (b == 0) b = 1;
         run_check("random", a, b, 0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_corner();
      test_ignore_init();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
